// File: rtl/cpu_sequencer_pkg.sv
// Shared opcode, field and state definitions for the CPU sequencer.
package cpu_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned FIELD_W = 6;
  localparam int unsigned JMP_W   = 8;

  localparam logic [OPC_W-1:0] OP_NOP       = 4'h0;
  localparam logic [OPC_W-1:0] OP_ALU_FIRST = 4'h1;
  localparam logic [OPC_W-1:0] OP_ALU_LAST  = 4'h8;
  localparam logic [OPC_W-1:0] OP_MOV       = 4'h9;
  localparam logic [OPC_W-1:0] OP_JMP       = 4'hB;
  localparam logic [OPC_W-1:0] OP_JZ        = 4'hC;
  localparam logic [OPC_W-1:0] OP_HALT      = 4'hF;

  // IDLE..HALT keep their 3-bit codes; WB needs a ninth value internally.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_RDA       = 4'd3,
    S_RDB       = 4'd4,
    S_ISSUE     = 4'd5,
    S_EXEC_WAIT = 4'd6,
    S_HALT      = 4'd7,
    S_WB        = 4'd8
  } state_e;

  // WB is reported on the 3-bit port under the execute-stage code.
  function automatic logic [2:0] state_code(state_e s);
    logic [3:0] v;
    v = s;
    return (s == S_WB) ? 3'd6 : v[2:0];
  endfunction

  function automatic logic is_alu(logic [OPC_W-1:0] op);
    return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
  endfunction

  function automatic logic is_illegal(logic [OPC_W-1:0] op);
    return (op == 4'hA) || (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Run/halt controlled fetch/decode/execute sequencer with handshaked ALU.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [PC_W-1:0]   rom_address,
  output logic              rom_read_enable,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_data_out,
  output logic [3:0]        alu_op,
  output logic              alu_enable,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_done,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        state,
  output logic              halted,
  output logic              error,
  output logic              illegal_op
);

  localparam int unsigned CNT_W = $clog2(ALU_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q;
  logic [DATA_W-1:0]   ir_q, opa_q, opb_q;
  logic                zflag_q;
  logic [CNT_W-1:0]    wcnt_q;
  logic                rom_re_q, ram_rd_q, ram_wr_q, alu_en_q;
  logic [ADDR_W-1:0]   ram_rd_addr_q, ram_wr_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic                halted_q, error_q, illegal_q;

  logic [OPC_W-1:0]    dec_op, ir_op;
  logic                timeout;
  state_e              boundary;

  assign dec_op   = rom_data[DATA_W-1 -: OPC_W];
  assign ir_op    = ir_q[DATA_W-1 -: OPC_W];
  assign timeout  = (wcnt_q == CNT_W'(ALU_TIMEOUT - 1));
  assign boundary = run ? S_FETCH : S_IDLE;

  // Next-state selection; the instruction boundary folds into DECODE/WB.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE: begin
        if (is_alu(dec_op))        state_d = S_RDA;
        else if (dec_op == OP_MOV) state_d = S_RDB;
        else if (dec_op == OP_HALT) state_d = S_HALT;
        else                       state_d = boundary;
      end
      S_RDA:       state_d = S_RDB;
      S_RDB:       state_d = S_ISSUE;
      S_ISSUE:     state_d = is_alu(ir_op) ? S_EXEC_WAIT : S_WB;
      S_EXEC_WAIT: begin
        if (alu_done)     state_d = S_WB;
        else if (timeout) state_d = S_HALT;
      end
      S_WB:        state_d = boundary;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath registers plus strobes registered against the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      ir_q          <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      zflag_q       <= 1'b0;
      wcnt_q        <= '0;
      rom_re_q      <= 1'b0;
      ram_rd_q      <= 1'b0;
      ram_rd_addr_q <= '0;
      ram_wr_q      <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wdata_q   <= '0;
      alu_en_q      <= 1'b0;
      halted_q      <= 1'b0;
      error_q       <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_re_q      <= 1'b0;
      ram_rd_q      <= 1'b0;
      ram_rd_addr_q <= '0;
      ram_wr_q      <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wdata_q   <= '0;
      alu_en_q      <= 1'b0;
      illegal_q     <= 1'b0;

      case (state_q)
        S_DECODE: begin
          ir_q      <= rom_data;
          illegal_q <= is_illegal(dec_op);
          if ((dec_op == OP_JMP) || ((dec_op == OP_JZ) && zflag_q))
            pc_q <= rom_data[PC_W-1:0];
          else
            pc_q <= pc_q + 1'b1;
        end
        S_RDB:   opa_q <= ram_data_in;
        S_ISSUE: begin
          opb_q <= ram_data_in;
          if (state_d == S_WB) ram_wdata_q <= ram_data_in;
        end
        S_EXEC_WAIT: begin
          wcnt_q <= wcnt_q + 1'b1;
          if (alu_done) begin
            zflag_q     <= alu_zero;
            ram_wdata_q <= alu_result;
          end else if (timeout) begin
            error_q <= 1'b1;
          end
        end
        default: ;
      endcase

      case (state_d)
        S_FETCH: rom_re_q <= 1'b1;
        S_RDA: begin
          ram_rd_q      <= 1'b1;
          ram_rd_addr_q <= rom_data[2*ADDR_W-1 -: ADDR_W];
        end
        S_RDB: begin
          ram_rd_q      <= 1'b1;
          ram_rd_addr_q <= (state_q == S_DECODE) ? rom_data[ADDR_W-1:0] : ir_q[ADDR_W-1:0];
        end
        S_EXEC_WAIT: begin
          if (state_q == S_ISSUE) begin
            alu_en_q <= 1'b1;
            wcnt_q   <= '0;
          end
        end
        S_WB: begin
          ram_wr_q      <= 1'b1;
          ram_wr_addr_q <= ir_q[2*ADDR_W-1 -: ADDR_W];
        end
        S_HALT:  halted_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign rom_address     = pc_q;
  assign rom_read_enable = rom_re_q;
  assign ram_read        = ram_rd_q;
  assign ram_read_addr   = ram_rd_addr_q;
  assign ram_write       = ram_wr_q;
  assign ram_write_addr  = ram_wr_addr_q;
  assign ram_data_out    = ram_wdata_q;
  assign alu_op          = ir_op;
  assign alu_enable      = alu_en_q;
  assign alu_a           = opa_q;
  assign alu_b           = opb_q;
  assign pc              = pc_q;
  assign state           = state_code(state_q);
  assign halted          = halted_q;
  assign error           = error_q;
  assign illegal_op      = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: ROM/RAM/ALU responders plus an instruction-level model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [7:0]  rom_address;
  logic        rom_read_enable;
  logic [15:0] rom_data;
  logic        ram_read;
  logic [5:0]  ram_read_addr;
  logic [15:0] ram_data_in;
  logic        ram_write;
  logic [5:0]  ram_write_addr;
  logic [15:0] ram_data_out;
  logic [3:0]  alu_op;
  logic        alu_enable;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        alu_zero, alu_done;
  logic [7:0]  pc;
  logic [2:0]  state;
  logic        halted, error, illegal_op;

  cpu_sequencer #(.PC_W(8), .DATA_W(16), .ADDR_W(6), .ALU_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run),
    .rom_address(rom_address), .rom_read_enable(rom_read_enable), .rom_data(rom_data),
    .ram_read(ram_read), .ram_read_addr(ram_read_addr), .ram_data_in(ram_data_in),
    .ram_write(ram_write), .ram_write_addr(ram_write_addr), .ram_data_out(ram_data_out),
    .alu_op(alu_op), .alu_enable(alu_enable), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_done(alu_done),
    .pc(pc), .state(state), .halted(halted), .error(error), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // ---------------- environment: ROM, RAM, ALU ----------------
  logic [15:0] rom     [256];
  logic [15:0] ram     [64];
  logic [15:0] ram_img [64];
  bit          ram_load = 1'b0;

  always @(posedge clk) begin
    if (rom_read_enable) rom_data <= rom[rom_address];
    if (ram_read)        ram_data_in <= ram[ram_read_addr];
    if (ram_load)        ram <= ram_img;
    else if (ram_write)  ram[ram_write_addr] <= ram_data_out;
  end

  function automatic logic [15:0] alu_fn(int op, logic [15:0] a, logic [15:0] b);
    case (op)
      1: return a + b;
      2: return a - b;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return a << b[3:0];
      7: return a >> b[3:0];
      8: return b - a;
      default: return 16'h0;
    endcase
  endfunction

  int  lat_tab [64];
  int  alu_idx, alu_age, cur_lat;
  bit  alu_busy;
  bit  alu_hang = 1'b0;

  always_comb begin
    cur_lat    = lat_tab[alu_idx % 64];
    alu_done   = !alu_hang && ((alu_enable && cur_lat == 0) || (alu_busy && alu_age == cur_lat));
    alu_result = alu_fn(int'(alu_op), alu_a, alu_b);
    alu_zero   = (alu_result == 16'h0);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_busy <= 1'b0;
      alu_age  <= 0;
      alu_idx  <= 0;
    end else if (alu_done) begin
      alu_busy <= 1'b0;
      alu_idx  <= alu_idx + 1;
    end else if (alu_enable) begin
      alu_busy <= 1'b1;
      alu_age  <= 1;
    end else if (alu_busy) begin
      alu_age <= alu_age + 1;
    end
  end

  // ---------------- monitor ----------------
  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit  mon_clr = 1'b0;
  int  f_addr[$], f_cyc[$], w_addr[$], w_data[$], w_cyc[$], w_pc[$];
  int  en_cnt, en_cyc, ill_cnt, ill_wide, viol, halt_cyc, err_cyc;
  bit  ill_prev;

  always @(negedge clk) begin
    if (mon_clr) begin
      f_addr.delete(); f_cyc.delete();
      w_addr.delete(); w_data.delete(); w_cyc.delete(); w_pc.delete();
      en_cnt <= 0; en_cyc <= -1; ill_cnt <= 0; ill_wide <= 0; viol <= 0;
      halt_cyc <= -1; err_cyc <= -1; ill_prev <= 1'b0;
    end else begin
      if (rom_read_enable) begin f_addr.push_back(int'(rom_address)); f_cyc.push_back(cyc); end
      if (ram_write) begin
        w_addr.push_back(int'(ram_write_addr)); w_data.push_back(int'(ram_data_out));
        w_cyc.push_back(cyc); w_pc.push_back(int'(pc));
      end
      if (alu_enable) begin en_cnt <= en_cnt + 1; en_cyc <= cyc; end
      if (illegal_op) ill_cnt <= ill_cnt + 1;
      if (illegal_op && ill_prev) ill_wide <= ill_wide + 1;
      ill_prev <= illegal_op;
      if ((!ram_read && ram_read_addr != 0) || (!ram_write && ram_write_addr != 0)) viol <= viol + 1;
      if (halted && halt_cyc < 0) halt_cyc <= cyc;
      if (error && err_cyc < 0) err_cyc <= cyc;
    end
  end

  // ---------------- reference model ----------------
  int          e_addr[$], e_data[$], e_rel[$];
  int          e_pc, e_halt_rel, e_alu, e_ill;
  logic [15:0] e_ram [64];

  task automatic model_run();
    logic [15:0] m [64];
    logic [15:0] ins, r;
    int p, c, k, op, d, s, t, guard;
    bit z;
    m = ram_img; p = 0; c = 0; k = 0; z = 0; guard = 0;
    e_addr.delete(); e_data.delete(); e_rel.delete();
    e_alu = 0; e_ill = 0; e_halt_rel = -1; e_pc = -1;
    while (guard < 1000) begin
      guard++;
      ins = rom[p];
      op = int'(ins[15:12]); d = int'(ins[11:6]); s = int'(ins[5:0]); t = int'(ins[7:0]);
      p = (p + 1) % 256;
      if (op >= 1 && op <= 8) begin
        r = alu_fn(op, m[d], m[s]);
        z = (r == 16'h0);
        e_addr.push_back(d); e_data.push_back(int'(r)); e_rel.push_back(c + 6 + lat_tab[k]);
        m[d] = r;
        c += 7 + lat_tab[k];
        k++; e_alu++;
      end else if (op == 9) begin
        e_addr.push_back(d); e_data.push_back(int'(m[s])); e_rel.push_back(c + 4);
        m[d] = m[s];
        c += 5;
      end else if (op == 11) begin
        p = t; c += 2;
      end else if (op == 12) begin
        if (z) p = t;
        c += 2;
      end else if (op == 15) begin
        e_halt_rel = c + 2; e_pc = p;
        break;
      end else begin
        if (op == 10 || op == 13 || op == 14) e_ill++;
        c += 2;
      end
    end
    e_ram = m;
  endtask

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    for (int i = 0; i < 64; i++) begin ram_img[i] = 16'h0; lat_tab[i] = 0; end
  endtask

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; mon_clr = 1'b1; ram_load = 1'b1;
    repeat (3) tick();
    ram_load = 1'b0; mon_clr = 1'b0; reset = 1'b1;
  endtask

  task automatic wait_halt(input int budget, output bit ok);
    int n = 0;
    while (!halted && n < budget) begin tick(); n++; end
    ok = halted;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_prog();
    reset = 1'b0; run = 1'b1;
    tick();
    chk_cnt++;
    if ({rom_read_enable, ram_read, ram_write, alu_enable, halted, error, illegal_op} !== 7'b0) $display("FAIL reset_strobes got=%b want=0", {rom_read_enable, ram_read, ram_write, alu_enable, halted, error, illegal_op});
    else pass_cnt++;
    chk_cnt++;
    if ({state, pc, alu_a, alu_b, alu_op} !== '0) $display("FAIL reset_regs state=%0d pc=%0h a=%0h b=%0h op=%0h want all 0", state, pc, alu_a, alu_b, alu_op);
    else pass_cnt++;
  endtask

  task automatic test_alu_add();
    bit ok;
    clear_prog();
    rom[0] = 16'h10C4; rom[1] = 16'hF000;
    ram_img[3] = 16'd5; ram_img[4] = 16'd7; lat_tab[0] = 1;
    do_reset(); run = 1'b1;
    wait_halt(60, ok);
    chk_cnt++;
    if (!ok) $display("FAIL add_halt_timeout halted=%b want 1", halted); else pass_cnt++;
    chk_cnt++;
    if (w_addr.size() != 1) $display("FAIL add_write_count got=%0d want 1", w_addr.size());
    else begin
      pass_cnt++;
      chk_cnt++;
      if (w_addr[0] != 3 || w_data[0] != 12) $display("FAIL add_write got addr=%0d data=%0d want 3/12", w_addr[0], w_data[0]); else pass_cnt++;
      chk_cnt++;
      if (w_cyc[0] - f_cyc[0] + 1 != 8) $display("FAIL add_write_cycle got=%0d want 8", w_cyc[0] - f_cyc[0] + 1); else pass_cnt++;
      chk_cnt++;
      if (w_pc[0] != 1) $display("FAIL add_pc_at_write got=%0d want 1", w_pc[0]); else pass_cnt++;
    end
    chk_cnt++;
    if (ram[3] !== 16'd12 || en_cnt != 1 || pc !== 8'd2 || state !== 3'd7) $display("FAIL add_final ram3=%0d en=%0d pc=%0d state=%0d want 12/1/2/7", ram[3], en_cnt, pc, state);
    else pass_cnt++;
  endtask

  task automatic test_mov();
    bit ok;
    clear_prog();
    rom[0] = 16'h9045; ram_img[5] = 16'hBEEF;
    do_reset(); run = 1'b1;
    wait_halt(40, ok);
    chk_cnt++;
    if (!ok || w_addr.size() != 1) $display("FAIL mov_write_count halted=%b writes=%0d want 1/1", halted, w_addr.size());
    else begin
      pass_cnt++;
      chk_cnt++;
      if (w_addr[0] != 1 || w_data[0] != 'hBEEF || w_cyc[0] - f_cyc[0] != 4) $display("FAIL mov_write got addr=%0d data=%0h rel=%0d want 1/beef/4", w_addr[0], w_data[0], w_cyc[0] - f_cyc[0]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (en_cnt != 0) $display("FAIL mov_alu_enable got=%0d want 0", en_cnt); else pass_cnt++;
  endtask

  task automatic test_jz();
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      clear_prog();
      rom[0] = (pass == 0) ? 16'h2082 : 16'h1082;
      rom[1] = 16'hC020; ram_img[2] = 16'd9;
      do_reset(); run = 1'b1;
      wait_halt(60, ok);
      chk_cnt++;
      if (!ok || f_addr.size() != 3) $display("FAIL jz_fetches pass=%0d halted=%b fetches=%0d want 1/3", pass, halted, f_addr.size());
      else begin
        pass_cnt++;
        chk_cnt++;
        if (f_addr[2] != ((pass == 0) ? 'h20 : 2)) $display("FAIL jz_target pass=%0d got=%0h want %0h", pass, f_addr[2], (pass == 0) ? 'h20 : 2);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_prog();
    rom[0] = 16'h10C4; alu_hang = 1'b1;
    do_reset(); run = 1'b1;
    wait_halt(80, ok);
    chk_cnt++;
    if (!ok || error !== 1'b1 || err_cyc - en_cyc != 15) $display("FAIL timeout_wait halted=%b error=%b waited=%0d want 1/1/15", halted, error, err_cyc - en_cyc);
    else pass_cnt++;
    chk_cnt++;
    if (w_addr.size() != 0) $display("FAIL timeout_no_write got=%0d writes want 0", w_addr.size()); else pass_cnt++;
    tick(); #2 reset = 1'b0; #1;
    chk_cnt++;
    if ({state, halted, error, rom_read_enable, ram_write, alu_enable, pc} !== '0) $display("FAIL timeout_reset state=%0d halted=%b error=%b pc=%0d want all 0", state, halted, error, pc);
    else pass_cnt++;
    alu_hang = 1'b0;
  endtask

  task automatic test_wrap_illegal();
    bit ok;
    int n = 0;
    clear_prog();
    rom[0] = 16'hB0FE; rom[8'hFE] = 16'hA000; rom[8'hFF] = 16'h0000;
    do_reset(); run = 1'b1;
    while (f_addr.size() < 3 && n < 40) begin tick(); n++; end
    rom[0] = 16'hF000;
    wait_halt(40, ok);
    chk_cnt++;
    if (!ok || f_addr.size() != 4) $display("FAIL wrap_fetches halted=%b fetches=%0d want 1/4", halted, f_addr.size());
    else begin
      pass_cnt++;
      chk_cnt++;
      if (f_addr[1] != 'hFE || f_addr[2] != 'hFF || f_addr[3] != 0 || pc !== 8'd1) $display("FAIL wrap_seq got %0h %0h %0h pc=%0h want fe ff 0 pc=1", f_addr[1], f_addr[2], f_addr[3], pc);
      else pass_cnt++;
    end
    chk_cnt++;
    if (ill_cnt != 1 || ill_wide != 0) $display("FAIL illegal_pulse cycles=%0d wide=%0d want 1/0", ill_cnt, ill_wide); else pass_cnt++;
  endtask

  task automatic test_run_drop();
    int n = 0;
    clear_prog();
    rom[0] = 16'h10C4; rom[1] = 16'h0000;
    ram_img[3] = 16'd5; ram_img[4] = 16'd7;
    do_reset(); run = 1'b1;
    while (state !== 3'd4 && n < 20) begin tick(); n++; end
    run = 1'b0;
    repeat (20) tick();
    chk_cnt++;
    if (w_addr.size() != 1 || f_addr.size() != 1 || state !== 3'd0 || halted !== 1'b0) $display("FAIL run_drop writes=%0d fetches=%0d state=%0d halted=%b want 1/1/0/0", w_addr.size(), f_addr.size(), state, halted);
    else pass_cnt++;
    chk_cnt++;
    if (ram[3] !== 16'd12) $display("FAIL run_drop_data got=%0d want 12", ram[3]); else pass_cnt++;
  endtask

  task automatic test_reset_exec();
    int n = 0;
    clear_prog();
    rom[0] = 16'h10C4; alu_hang = 1'b1;
    do_reset(); run = 1'b1;
    while (en_cnt == 0 && n < 20) begin tick(); n++; end
    repeat (3) tick();
    #2 reset = 1'b0; #1;
    chk_cnt++;
    if (state !== 3'd0 || ram_write !== 1'b0 || alu_enable !== 1'b0 || n >= 20) $display("FAIL reset_exec state=%0d ram_write=%b en=%b wait=%0d want 0/0/0/<20", state, ram_write, alu_enable, n);
    else pass_cnt++;
    repeat (5) tick();
    chk_cnt++;
    if (w_addr.size() != 0) $display("FAIL reset_exec_no_write got=%0d want 0", w_addr.size()); else pass_cnt++;
    alu_hang = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    int n, kind, op, bad;
    for (int it = 0; it < 8; it++) begin
      clear_prog();
      n = $urandom_range(4, 20);
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 9);
        if (kind <= 4)      op = $urandom_range(1, 8);
        else if (kind == 5) op = 9;
        else if (kind == 6) op = 0;
        else if (kind == 7) op = (it % 3 == 0) ? 10 : ((it % 3 == 1) ? 13 : 14);
        else                op = (kind == 8) ? 12 : 11;
        if (op == 11 || op == 12)
          rom[i] = {op[3:0], 4'h0, 8'(i + 2)};
        else
          rom[i] = {op[3:0], 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      end
      for (int i = 0; i < 8; i++) ram_img[i] = 16'($urandom_range(0, 3));
      for (int i = 0; i < 64; i++) lat_tab[i] = $urandom_range(0, 3);
      model_run();
      do_reset(); run = 1'b1;
      wait_halt(2000, ok);
      chk_cnt++;
      if (!ok || w_addr.size() != e_addr.size()) $display("FAIL rand_writes it=%0d halted=%b got=%0d want %0d", it, halted, w_addr.size(), e_addr.size());
      else begin
        pass_cnt++;
        bad = 0;
        for (int j = 0; j < w_addr.size(); j++)
          if (w_addr[j] != e_addr[j] || w_data[j] != e_data[j] || w_cyc[j] - f_cyc[0] != e_rel[j]) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL rand_write_stream it=%0d bad_entries=%0d want 0", it, bad); else pass_cnt++;
        chk_cnt++;
        if (int'(pc) != e_pc || halt_cyc - f_cyc[0] != e_halt_rel) $display("FAIL rand_halt it=%0d pc=%0d rel=%0d want %0d/%0d", it, pc, halt_cyc - f_cyc[0], e_pc, e_halt_rel);
        else pass_cnt++;
      end
      bad = 0;
      for (int a = 0; a < 8; a++) if (ram[a] !== e_ram[a]) bad++;
      chk_cnt++;
      if (bad != 0 || en_cnt != e_alu || ill_cnt != e_ill || viol != 0) $display("FAIL rand_state it=%0d ram_bad=%0d en=%0d/%0d ill=%0d/%0d addr_viol=%0d", it, bad, en_cnt, e_alu, ill_cnt, e_ill, viol);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset = 1'b0; run = 1'b0;
    test_reset();
    test_alu_add();
    test_mov();
    test_jz();
    test_timeout();
    test_wrap_illegal();
    test_run_drop();
    test_reset_exec();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
